nun_chuck_tx: RTL and testbench

Packet transmitter for the joystick link: it is the sending end of the 3-byte X / Y / Z-button frame that `nun_chuck` reassembles. It captures an 8-bit X value, an 8-bit Y value and the Z button on a send request. It then hands them one byte at a time to a byte-level serial transmitter (UART TX), waiting for that transmitter's completion pulse before each next byte. It sits between the joystick sampling logic and the serial byte transmitter on the controller side of the link.

---
 rtl/nun_chuck_tx.sv | 131 +++++++++++++
 tb/tb_nun_chuck_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/nun_chuck_tx.sv
// Sends one captured X / Y / Z-button sample as a 3-byte frame to a byte-level serial transmitter.
// Bytes are handed over one at a time; each waits for the transmitter's completion pulse before the next.
module nun_chuck_tx #(
  parameter int GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] x_in,
  input  logic [7:0] y_in,
  input  logic       z_in,
  input  logic       send_tick,
  input  logic       byte_done_tick,
  output logic [7:0] byte_out,
  output logic       byte_start_tick,
  output logic       busy,
  output logic       done_tick
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } state_e;

  // Terminal count of the inter-byte gap counter; unused when no gap is configured.
  localparam logic [7:0] GapLast = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
  localparam bit         HasGap  = (GAP_CYCLES > 0);

  state_e     state_q;
  logic [1:0] idx_q;
  logic [7:0] gap_q;
  logic [7:0] x_q;
  logic [7:0] y_q;
  logic       z_q;
  logic [7:0] byte_q;
  logic       start_q;
  logic       busy_q;
  logic       done_q;
  logic [1:0] idx_d;

  function automatic logic [7:0] pick_byte(input logic [1:0] idx,
                                           input logic [7:0] xv,
                                           input logic [7:0] yv,
                                           input logic       zv);
    logic [7:0] b;
    case (idx)
      2'd0:    b = xv;
      2'd1:    b = yv;
      2'd2:    b = {7'b0, zv};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign idx_d = idx_q + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      gap_q   <= 8'd0;
      x_q     <= 8'd0;
      y_q     <= 8'd0;
      z_q     <= 1'b0;
      byte_q  <= 8'd0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (send_tick) begin
            x_q     <= x_in;
            y_q     <= y_in;
            z_q     <= z_in;
            idx_q   <= 2'd0;
            byte_q  <= x_in;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= SEND;
          end
        end
        SEND: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (byte_done_tick) begin
            if (idx_q == 2'd2) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              idx_q <= idx_d;
              if (HasGap) begin
                gap_q   <= 8'd0;
                state_q <= GAP;
              end else begin
                byte_q  <= pick_byte(idx_d, x_q, y_q, z_q);
                start_q <= 1'b1;
                state_q <= SEND;
              end
            end
          end
        end
        GAP: begin
          // The index was already advanced on leaving WAIT.
          if (gap_q == GapLast) begin
            byte_q  <= pick_byte(idx_q, x_q, y_q, z_q);
            start_q <= 1'b1;
            state_q <= SEND;
          end else begin
            gap_q <= gap_q + 8'd1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign byte_out        = byte_q;
  assign byte_start_tick = start_q;
  assign busy            = busy_q;
  assign done_tick       = done_q;

endmodule

// File: tb/tb_nun_chuck_tx.sv
// Directed bench for nun_chuck_tx: a no-gap and a 4-cycle-gap instance share stimulus, selected by sel.
// Inputs change on the falling edge; outputs are observed on the falling edge.
module tb_nun_chuck_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] x_in = 8'h00;
  logic [7:0] y_in = 8'h00;
  logic       z_in = 1'b0;
  logic       send = 1'b0;
  logic       done = 1'b0;
  logic       sel = 1'b0;

  logic [7:0] bo0, bo4, bo;
  logic       st0, st4, st;
  logic       bz0, bz4, bz;
  logic       dn0, dn4, dn;
  logic       send0, send4, done0, done4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign send0 = send & ~sel;
  assign send4 = send & sel;
  assign done0 = done & ~sel;
  assign done4 = done & sel;
  assign bo = sel ? bo4 : bo0;
  assign st = sel ? st4 : st0;
  assign bz = sel ? bz4 : bz0;
  assign dn = sel ? dn4 : dn0;

  nun_chuck_tx #(.GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .send_tick(send0), .byte_done_tick(done0),
    .byte_out(bo0), .byte_start_tick(st0), .busy(bz0), .done_tick(dn0)
  );

  nun_chuck_tx #(.GAP_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .send_tick(send4), .byte_done_tick(done4),
    .byte_out(bo4), .byte_start_tick(st4), .busy(bz4), .done_tick(dn4)
  );

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic       z;
    int         dly;
    logic       g4;
    logic [7:0] e0;
    logic [7:0] e1;
    logic [7:0] e2;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_start(input string name, input int explat);
    int lat = 0;
    while (st !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk(name, lat, explat);
  endtask

  // Issues send_tick in the current cycle and plays the byte transmitter.
  // Returns in the cycle after the third byte_done_tick, where done_tick is due.
  task automatic run_frame(input logic [7:0] x, input logic [7:0] y, input logic z,
                           input int dly, input int gap,
                           input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                           input bit disturb, input bit done_in_send);
    logic [7:0] eb;
    x_in = x;
    y_in = y;
    z_in = z;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    for (int b = 0; b < 3; b++) begin
      eb = (b == 0) ? e0 : (b == 1) ? e1 : e2;
      wait_start("start_latency", (b == 0) ? 0 : gap);
      chk("byte_out_at_start", 32'(bo), 32'(eb));
      chk("busy_in_send", 32'(bz), 32'd1);
      done = done_in_send && (b == 1);
      @(negedge clk);
      done = 1'b0;
      chk("start_single_cycle", 32'(st), 32'd0);
      if (disturb && b == 0) begin
        x_in = 8'h77;
        y_in = 8'h88;
        z_in = ~z;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        chk("no_restart_when_busy", 32'(st), 32'd0);
        repeat (dly - 2) @(negedge clk);
      end else begin
        repeat (dly - 1) @(negedge clk);
      end
      done = 1'b1;
      chk("busy_in_wait", 32'(bz), 32'd1);
      chk("byte_out_stable", 32'(bo), 32'(eb));
      @(negedge clk);
      done = 1'b0;
    end
    chk("done_tick", 32'(dn), 32'd1);
    chk("busy_after_frame", 32'(bz), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{x: 8'hA5, y: 8'h3C, z: 1'b1, dly: 10, g4: 1'b0, e0: 8'hA5, e1: 8'h3C, e2: 8'h01};
    vecs[1] = '{x: 8'h12, y: 8'hFE, z: 1'b0, dly: 3,  g4: 1'b0, e0: 8'h12, e1: 8'hFE, e2: 8'h00};
    vecs[2] = '{x: 8'hFF, y: 8'h00, z: 1'b1, dly: 1,  g4: 1'b1, e0: 8'hFF, e1: 8'h00, e2: 8'h01};
    vecs[3] = '{x: 8'h5A, y: 8'h81, z: 1'b0, dly: 1,  g4: 1'b1, e0: 8'h5A, e1: 8'h81, e2: 8'h00};

    repeat (3) @(negedge clk);
    chk("rst_byte_out0", 32'(bo0), 32'd0);
    chk("rst_start0", 32'(st0), 32'd0);
    chk("rst_busy0", 32'(bz0), 32'd0);
    chk("rst_done0", 32'(dn0), 32'd0);
    chk("rst_byte_out4", 32'(bo4), 32'd0);
    chk("rst_busy4", 32'(bz4), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // byte_done_tick in IDLE must do nothing
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("idle_done_start", 32'(st), 32'd0);
    chk("idle_done_busy", 32'(bz), 32'd0);
    @(negedge clk);
    chk("idle_done_start2", 32'(st), 32'd0);

    for (int i = 0; i < 4; i++) begin
      sel = vecs[i].g4;
      @(negedge clk);
      run_frame(vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].dly, vecs[i].g4 ? 4 : 0,
                vecs[i].e0, vecs[i].e1, vecs[i].e2, 1'b0, 1'b0);
      @(negedge clk);
      chk("done_tick_pulse", 32'(dn), 32'd0);
      chk("idle_busy", 32'(bz), 32'd0);
    end

    // Mid-frame send/x change ignored; byte_done_tick in SEND ignored
    sel = 1'b0;
    @(negedge clk);
    run_frame(8'h11, 8'h22, 1'b1, 4, 0, 8'h11, 8'h22, 8'h01, 1'b1, 1'b1);
    @(negedge clk);
    sel = 1'b1;
    @(negedge clk);
    run_frame(8'h33, 8'h44, 1'b0, 4, 4, 8'h33, 8'h44, 8'h00, 1'b1, 1'b1);
    @(negedge clk);

    // Back-to-back frames: second send lands in the done_tick cycle
    sel = 1'b0;
    @(negedge clk);
    run_frame(8'hA1, 8'hB2, 1'b0, 2, 0, 8'hA1, 8'hB2, 8'h00, 1'b0, 1'b0);
    run_frame(8'hC3, 8'hD4, 1'b1, 2, 0, 8'hC3, 8'hD4, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    sel = 1'b1;
    @(negedge clk);
    run_frame(8'h0F, 8'hF0, 1'b1, 1, 4, 8'h0F, 8'hF0, 8'h01, 1'b0, 1'b0);
    run_frame(8'hE7, 8'h7E, 1'b0, 1, 4, 8'hE7, 8'h7E, 8'h00, 1'b0, 1'b0);
    @(negedge clk);

    // Asynchronous reset during WAIT of byte 1
    sel = 1'b0;
    @(negedge clk);
    x_in = 8'h31;
    y_in = 8'h42;
    z_in = 1'b1;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    wait_start("rst_seq_start0", 0);
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    wait_start("rst_seq_start1", 0);
    chk("rst_seq_byte1", 32'(bo), 32'h42);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_byte_out", 32'(bo0), 32'd0);
    chk("midrst_start", 32'(st0), 32'd0);
    chk("midrst_busy", 32'(bz0), 32'd0);
    chk("midrst_done", 32'(dn0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      done = (c == 3);
      @(negedge clk);
      if (st0 === 1'b1 || bz0 === 1'b1) n++;
    end
    done = 1'b0;
    chk("no_resume_after_reset", n, 0);
    run_frame(8'h66, 8'h99, 1'b0, 2, 0, 8'h66, 8'h99, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk("final_done_pulse", 32'(dn), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
